// File: rtl/clk_div_prog.sv
// clk_div_prog
// Multi-channel programmable clock divider. Every channel counts 0..div-1 and
// drives a registered divided clock plus a one-cycle tick at the end of each
// period. New ratios arrive through a single-entry valid/ready slot and are
// applied only when the target channel wraps, so a period is never cut short.
//
// Optional feature macro: CLKDIV_SYNC_EN
//   When defined, adds input sync_in. A high cycle restarts every channel at
//   cnt=0 on the next edge and applies any pending ratio at once.
//   When undefined, channels are only aligned by reset.
module clk_div_prog #(
  parameter int NUM_CH  = 2,
  parameter int CNT_W   = 8,
  parameter int DEF_DIV = 4,
  parameter int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
`ifdef CLKDIV_SYNC_EN
  input  logic              sync_in,
`endif
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [CH_W-1:0]   cfg_ch,
  input  logic [CNT_W-1:0]  cfg_div,
  output logic              cfg_err,
  output logic [NUM_CH-1:0] clk_out,
  output logic [NUM_CH-1:0] tick
);

  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] TWO = CNT_W'(2);

  // Per-channel counter and active ratio
  logic [CNT_W-1:0]  cnt_q [NUM_CH];
  logic [CNT_W-1:0]  cnt_d [NUM_CH];
  logic [CNT_W-1:0]  div_q [NUM_CH];
  logic [CNT_W-1:0]  div_d [NUM_CH];

  // Registered output decodes
  logic [NUM_CH-1:0] clk_q;
  logic [NUM_CH-1:0] clk_d;
  logic [NUM_CH-1:0] tick_q;
  logic [NUM_CH-1:0] tick_d;

  // Single pending update slot
  logic              pend_vld_q;
  logic              pend_vld_d;
  logic [CH_W-1:0]   pend_ch_q;
  logic [CH_W-1:0]   pend_ch_d;
  logic [CNT_W-1:0]  pend_div_q;
  logic [CNT_W-1:0]  pend_div_d;

  logic              err_q;
  logic              err_d;

  logic              sync_w;
  logic              cfg_fire;
  logic              cfg_bad;
  logic              applied;
  logic              wrap;
  logic              hit;

`ifdef CLKDIV_SYNC_EN
  assign sync_w = sync_in;
`else
  assign sync_w = 1'b0;
`endif

  // Handshake: a request transfers on a cycle where cfg_valid and cfg_ready
  // are both high. cfg_ready is simply "slot empty"; it falls the cycle after
  // a good request is taken and rises the cycle after that request is applied.
  // While cfg_ready is low cfg_valid is ignored and the requester holds its
  // request. A bad request (ratio < 2 or channel out of range) is taken,
  // discarded, and flagged by a one-cycle cfg_err; the slot stays free.
  assign cfg_fire = cfg_valid & ~pend_vld_q;
  assign cfg_bad  = (cfg_div < TWO) || (32'(cfg_ch) >= 32'(NUM_CH));

  // Next-state: counters, ratio apply on wrap (or sync), output decodes, slot
  always_comb begin
    pend_vld_d = pend_vld_q;
    pend_ch_d  = pend_ch_q;
    pend_div_d = pend_div_q;
    err_d      = 1'b0;
    applied    = 1'b0;
    wrap       = 1'b0;
    hit        = 1'b0;
    clk_d      = '0;
    tick_d     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      // Ratio >= 2 is guaranteed, so div-1 never underflows in CNT_W bits.
      wrap     = (cnt_q[i] == (div_q[i] - ONE));
      hit      = pend_vld_q && (pend_ch_q == CH_W'(i));
      cnt_d[i] = wrap ? '0 : (cnt_q[i] + ONE);
      div_d[i] = div_q[i];
      if (hit && (wrap || sync_w)) begin
        div_d[i] = pend_div_q;
        applied  = 1'b1;
      end
      if (sync_w) begin
        cnt_d[i] = '0;
      end
      // Outputs are registered copies of the decode of the next state, so
      // they line up with the counter value in the same cycle.
      clk_d[i]  = !sync_w && (cnt_d[i] >= (div_d[i] >> 1));
      tick_d[i] = !sync_w && (cnt_d[i] == (div_d[i] - ONE));
    end
    if (applied) begin
      pend_vld_d = 1'b0;
    end
    if (cfg_fire) begin
      if (cfg_bad) begin
        err_d = 1'b1;
      end else begin
        pend_vld_d = 1'b1;
        pend_ch_d  = cfg_ch;
        pend_div_d = cfg_div;
      end
    end
  end

  // State registers; synchronous reset dominates and drops any pending update
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= '0;
        div_q[i] <= CNT_W'(DEF_DIV);
      end
      clk_q      <= '0;
      tick_q     <= '0;
      pend_vld_q <= 1'b0;
      pend_ch_q  <= '0;
      pend_div_q <= '0;
      err_q      <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        cnt_q[i] <= cnt_d[i];
        div_q[i] <= div_d[i];
      end
      clk_q      <= clk_d;
      tick_q     <= tick_d;
      pend_vld_q <= pend_vld_d;
      pend_ch_q  <= pend_ch_d;
      pend_div_q <= pend_div_d;
      err_q      <= err_d;
    end
  end

  assign clk_out   = clk_q;
  assign tick      = tick_q;
  assign cfg_ready = ~pend_vld_q;
  assign cfg_err   = err_q;

endmodule

// File: tb/tb_clk_div_prog.sv
// Testbench for clk_div_prog (NUM_CH=2, CNT_W=8, DEF_DIV=4, CH_W=2 so that
// out-of-range channel numbers can be driven). A behavioural model tracks each
// channel as "cycle number of the current period start" plus ratio, and derives
// outputs from (cycle - start) mod ratio.
module tb_clk_div_prog;

  localparam int NUM_CH  = 2;
  localparam int DEF_DIV = 4;

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       sync_drv = 1'b0;
  logic       cfg_valid = 1'b0;
  logic [1:0] cfg_ch = '0;
  logic [7:0] cfg_div = '0;
  logic       cfg_ready;
  logic       cfg_err;
  logic [1:0] clk_out;
  logic [1:0] tick;

  always #5 clock = ~clock;

  clk_div_prog #(.NUM_CH(2), .CNT_W(8), .DEF_DIV(4), .CH_W(2)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef CLKDIV_SYNC_EN
    .sync_in   (sync_drv),
`endif
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_ch    (cfg_ch),
    .cfg_div   (cfg_div),
    .cfg_err   (cfg_err),
    .clk_out   (clk_out),
    .tick      (tick)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s @cyc %0d: actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  int m_start [NUM_CH] = '{0, 0};
  int m_div   [NUM_CH] = '{DEF_DIV, DEF_DIV};
  bit m_pv   = 1'b0;
  int m_pch  = 0;
  int m_pdiv = 0;
  bit m_err  = 1'b0;
  bit m_live = 1'b0;

  function automatic int m_phase(input int i);
    return (cyc - m_start[i]) % m_div[i];
  endfunction

  // One clock: advance the model from the driven inputs, take the edge,
  // then compare the DUT against the model 1 time unit later.
  task automatic step();
    int  n_start [NUM_CH];
    int  n_div   [NUM_CH];
    bit  n_pv, n_err, applied;
    int  n_pch, n_pdiv, ph;
    logic [1:0] e_clk, e_tk;
    n_start = m_start;
    n_div   = m_div;
    n_pv    = m_pv;
    n_pch   = m_pch;
    n_pdiv  = m_pdiv;
    n_err   = 1'b0;
    applied = 1'b0;
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        n_start[i] = cyc + 1;
        n_div[i]   = DEF_DIV;
      end
      n_pv = 1'b0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        ph = m_phase(i);
        if (m_pv && m_pch == i && (ph == m_div[i] - 1 || sync_drv)) begin
          n_div[i]   = m_pdiv;
          n_start[i] = cyc + 1;
          applied    = 1'b1;
        end else if (sync_drv) begin
          n_start[i] = cyc + 1;
        end
      end
      if (applied) n_pv = 1'b0;
      if (cfg_valid && !m_pv) begin
        if (int'(cfg_div) < 2 || int'(cfg_ch) >= NUM_CH) begin
          n_err = 1'b1;
        end else begin
          n_pv   = 1'b1;
          n_pch  = int'(cfg_ch);
          n_pdiv = int'(cfg_div);
        end
      end
    end
    @(posedge clock);
    cyc++;
    if (reset) m_live = 1'b1;
    m_start = n_start;
    m_div   = n_div;
    m_pv    = n_pv;
    m_pch   = n_pch;
    m_pdiv  = n_pdiv;
    m_err   = n_err;
    #1;
    if (m_live) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ph = m_phase(i);
        e_clk[i] = (ph >= m_div[i] / 2);
        e_tk[i]  = (ph == m_div[i] - 1);
      end
      chk("model_clk_out", 32'(clk_out), 32'(e_clk));
      chk("model_tick", 32'(tick), 32'(e_tk));
      chk("model_cfg_ready", 32'(cfg_ready), 32'(!m_pv));
      chk("model_cfg_err", 32'(cfg_err), 32'(m_err));
    end
  endtask

  // ---------------- driver tasks ----------------
  // Hold a request until taken, then run until the slot frees again; on
  // return the target channel sits at the first cycle of its new period.
  task automatic set_div(input int ch, input int dv);
    int guard = 0;
    cfg_valid = 1'b1;
    cfg_ch    = 2'(ch);
    cfg_div   = 8'(dv);
    while (!cfg_ready && guard < 600) begin step(); guard++; end
    step();
    cfg_valid = 1'b0;
    guard = 0;
    while (!cfg_ready && guard < 600) begin step(); guard++; end
    chk("set_div_bounded", 32'(guard < 600), 32'd1);
  endtask

  // Starting at cnt=0 of channel ch, watch two periods.
  task automatic check_period(input int ch, input int dv);
    int first = -1;
    int second = -1;
    int highs = 0;
    for (int k = 0; k < 2 * dv; k++) begin
      if (k > 0) step();
      if (tick[ch]) begin
        if (first < 0) first = k;
        else if (second < 0) second = k;
      end
      if (k < dv && clk_out[ch]) highs++;
    end
    chk($sformatf("first_tick_div%0d", dv), 32'(first), 32'(dv - 1));
    chk($sformatf("second_tick_div%0d", dv), 32'(second), 32'(2 * dv - 1));
    chk($sformatf("high_cycles_div%0d", dv), 32'(highs), 32'(dv - dv / 2));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic       rst;
    logic       vld;
    logic [1:0] ch;
    logic [7:0] dv;
    logic [1:0] e_clk;
    logic [1:0] e_tick;
    logic       e_rdy;
    logic       e_err;
  } vec_t;

  vec_t tbl [19];

  function automatic vec_t mk(input logic r, input logic v, input logic [1:0] c,
                              input logic [7:0] d, input logic [1:0] ec,
                              input logic [1:0] et, input logic er, input logic ee);
    vec_t x;
    x.rst = r; x.vld = v; x.ch = c; x.dv = d;
    x.e_clk = ec; x.e_tick = et; x.e_rdy = er; x.e_err = ee;
    return x;
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    logic [7:0] pat_clk;
    int         lows;
    int         both_cnt, both_first;
    logic       acc;

    // Expected outputs after each row's clock edge; vector bits are {ch1,ch0}.
    tbl[0]  = mk(1, 0, 0, 0, 2'b00, 2'b00, 1, 0);  // reset
    tbl[1]  = mk(1, 0, 0, 0, 2'b00, 2'b00, 1, 0);  // reset, cnt=0
    tbl[2]  = mk(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);  // cnt=1
    tbl[3]  = mk(0, 0, 0, 0, 2'b11, 2'b00, 1, 0);  // cnt=2
    tbl[4]  = mk(0, 0, 0, 0, 2'b11, 2'b11, 1, 0);  // cnt=3
    tbl[5]  = mk(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);  // cnt=0
    tbl[6]  = mk(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);  // cnt=1
    tbl[7]  = mk(0, 1, 0, 6, 2'b11, 2'b00, 0, 0);  // accept ch0 div6 at cnt=1
    tbl[8]  = mk(0, 0, 0, 0, 2'b11, 2'b11, 0, 0);  // cnt=3, still pending
    tbl[9]  = mk(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);  // applied, ready back
    tbl[10] = mk(0, 0, 0, 0, 2'b00, 2'b00, 1, 0);
    tbl[11] = mk(0, 0, 0, 0, 2'b10, 2'b00, 1, 0);
    tbl[12] = mk(0, 0, 0, 0, 2'b11, 2'b10, 1, 0);
    tbl[13] = mk(0, 0, 0, 0, 2'b01, 2'b00, 1, 0);
    tbl[14] = mk(0, 0, 0, 0, 2'b01, 2'b01, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 2'b10, 2'b00, 1, 0);
    tbl[16] = mk(0, 1, 0, 1, 2'b10, 2'b10, 1, 1);  // div=1 rejected
    tbl[17] = mk(0, 1, 3, 5, 2'b00, 2'b00, 1, 1);  // ch=3 rejected
    tbl[18] = mk(0, 0, 0, 0, 2'b01, 2'b00, 1, 0);

    #1;
    for (int r = 0; r < 19; r++) begin
      reset     = tbl[r].rst;
      cfg_valid = tbl[r].vld;
      cfg_ch    = tbl[r].ch;
      cfg_div   = tbl[r].dv;
      step();
      chk($sformatf("tbl%0d_clk_out", r), 32'(clk_out), 32'(tbl[r].e_clk));
      chk($sformatf("tbl%0d_tick", r), 32'(tick), 32'(tbl[r].e_tick));
      chk($sformatf("tbl%0d_cfg_ready", r), 32'(cfg_ready), 32'(tbl[r].e_rdy));
      chk($sformatf("tbl%0d_cfg_err", r), 32'(cfg_err), 32'(tbl[r].e_err));
    end
    reset = 1'b0;
    cfg_valid = 1'b0;

    // Odd ratio, minimum ratio and maximum ratio.
    set_div(1, 5);
    check_period(1, 5);
    set_div(0, 2);
    check_period(0, 2);
    set_div(1, 255);
    check_period(1, 255);

    // Reset with an update pending: update is lost, ratios return to 4.
    set_div(0, 4);
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd9;
    step();
    cfg_valid = 1'b0;
    chk("pend_ready_low", 32'(cfg_ready), 32'd0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_clk_out", 32'(clk_out), 32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_cfg_ready", 32'(cfg_ready), 32'd1);
    chk("rst_cfg_err", 32'(cfg_err), 32'd0);
    pat_clk = '0;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) step();
      pat_clk = {pat_clk[6:0], clk_out[0]};
    end
    chk("rst_ch0_pattern", 32'(pat_clk), 32'(8'b00110011));

    // Same ratio still waits for the wrap: taken at cnt=0, low 3 cycles.
    step();
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 8'd4;
    step();
    cfg_valid = 1'b0;
    lows = 0;
    while (!cfg_ready && lows < 20) begin lows++; step(); end
    chk("same_ratio_wait", 32'(lows), 32'd3);

    // Randomised traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      reset = ($urandom_range(0, 299) == 0);
`ifdef CLKDIV_SYNC_EN
      sync_drv = ($urandom_range(0, 149) == 0);
`endif
      acc = cfg_valid && cfg_ready && !reset;
      step();
      if (acc) cfg_valid = 1'b0;
      if (!cfg_valid && $urandom_range(0, 3) == 0) begin
        cfg_valid = 1'b1;
        cfg_ch  = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(2, 3))
                                              : 2'($urandom_range(0, 1));
        cfg_div = ($urandom_range(0, 9) == 0) ? 8'($urandom_range(0, 1))
                                              : 8'($urandom_range(2, 12));
      end
    end
    reset = 1'b0;
    sync_drv = 1'b0;
    cfg_valid = 1'b0;
    step();

`ifdef CLKDIV_SYNC_EN
    // div 3 and div 4 free-running, then a sync pulse realigns them.
    set_div(0, 3);
    set_div(1, 4);
    for (int k = 0; k < 5; k++) step();
    sync_drv = 1'b1;
    step();
    sync_drv = 1'b0;
    chk("sync_clk_out", 32'(clk_out), 32'd0);
    chk("sync_tick", 32'(tick), 32'd0);
    both_cnt = 0;
    both_first = -1;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      if (tick == 2'b11) begin
        both_cnt++;
        if (both_first < 0) both_first = k;
      end
    end
    chk("sync_common_first", 32'(both_first), 32'd11);
    chk("sync_common_count", 32'(both_cnt), 32'd2);
`else
    both_cnt = 0;
    both_first = 0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
